// File: rtl/gon_rr_gather_bus.sv
// gon_rr_gather_bus: round-robin gather of tag-matched PE ports into one registered slave port
`ifndef NUMS_PE_COL
`define NUMS_PE_COL 8
`endif
`ifndef XID_BITS
`define XID_BITS 4
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

module gon_rr_gather_bus #(
   parameter int NUMS_MASTER = `NUMS_PE_COL,
   parameter int ID_SIZE     = `XID_BITS,
   parameter int DATA_WIDTH  = `DATA_BITS,
   parameter int SRC_BITS    = (NUMS_MASTER > 1) ? $clog2(NUMS_MASTER) : 1
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ID_SIZE-1:0]            tag,
   input  logic [NUMS_MASTER-1:0]        master_valid,
   input  logic [NUMS_MASTER*DATA_WIDTH-1:0] master_data,
   output logic [NUMS_MASTER-1:0]        master_ready,
   output logic                          slave_valid,
   input  logic                          slave_ready,
   output logic [DATA_WIDTH-1:0]         slave_data,
   output logic [SRC_BITS-1:0]           slave_src,
   input  logic                          set_id,
   input  logic [ID_SIZE-1:0]            ID_scan_in,
   output logic [ID_SIZE-1:0]            ID_scan_out
);
   logic [ID_SIZE-1:0]     r_id [NUMS_MASTER];
   logic [SRC_BITS-1:0]    r_ptr;
   logic                   r_valid;
   logic [DATA_WIDTH-1:0]  r_data;
   logic [SRC_BITS-1:0]    r_src;
   logic [NUMS_MASTER-1:0] w_elig;
   logic                   w_found;
   logic [SRC_BITS-1:0]    w_win;
   logic                   w_load;
   logic                   w_xfer;
   logic [DATA_WIDTH-1:0]  w_data;

   // a port may compete only while its scanned ID matches the tag and no scan is in progress
   always_comb begin
      for (int i = 0; i < NUMS_MASTER; i++)
         w_elig[i] = master_valid[i] & (r_id[i] == tag) & ~set_id;
   end

   // first eligible port at or after the pointer, wrapping around
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 0; k < NUMS_MASTER; k++) begin
         if (!w_found && w_elig[(int'(r_ptr) + k) % NUMS_MASTER]) begin
            w_found = 1'b1;
            w_win   = SRC_BITS'((int'(r_ptr) + k) % NUMS_MASTER);
         end
      end
   end

   assign w_load       = ~r_valid | slave_ready;
   assign w_xfer       = w_found & w_load;
   assign w_data       = master_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
   assign master_ready = w_xfer ? (NUMS_MASTER'(1) << w_win) : '0;
   assign slave_valid  = r_valid;
   assign slave_data   = r_data;
   assign slave_src    = r_src;
   assign ID_scan_out  = r_id[NUMS_MASTER-1];

   // ID scan chain enters at port 0 and shifts toward the last port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUMS_MASTER; i++) r_id[i] <= '0;
      end else if (set_id) begin
         r_id[0] <= ID_scan_in;
         for (int i = 1; i < NUMS_MASTER; i++) r_id[i] <= r_id[i-1];
      end
   end

   // output register and round-robin pointer; a transfer replaces the word in place
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_src   <= '0;
         r_ptr   <= '0;
      end else if (w_xfer) begin
         r_valid <= 1'b1;
         r_data  <= w_data;
         r_src   <= w_win;
         r_ptr   <= (int'(w_win) == NUMS_MASTER - 1) ? '0 : w_win + SRC_BITS'(1);
      end else if (slave_ready) begin
         r_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_gon_rr_gather_bus.sv
// tb_gon_rr_gather_bus: directed stimulus checked by a behavioural model plus literal expectations
module tb_gon_rr_gather_bus;
   localparam int N = 8;
   localparam int IW = 4;
   localparam int DW = 8;
   localparam int SW = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [IW-1:0]   tag = '0;
   logic [N-1:0]    master_valid = '0;
   logic [N*DW-1:0] master_data = '0;
   logic [N-1:0]    master_ready;
   logic            slave_valid;
   logic            slave_ready = 1'b0;
   logic [DW-1:0]   slave_data;
   logic [SW-1:0]   slave_src;
   logic            set_id = 1'b0;
   logic [IW-1:0]   ID_scan_in = '0;
   logic [IW-1:0]   ID_scan_out;

   int errors = 0;
   int checks = 0;

   gon_rr_gather_bus #(.NUMS_MASTER(N), .ID_SIZE(IW), .DATA_WIDTH(DW), .SRC_BITS(SW)) dut (
      .clk(clk), .rst(rst), .tag(tag), .master_valid(master_valid), .master_data(master_data),
      .master_ready(master_ready), .slave_valid(slave_valid), .slave_ready(slave_ready),
      .slave_data(slave_data), .slave_src(slave_src), .set_id(set_id),
      .ID_scan_in(ID_scan_in), .ID_scan_out(ID_scan_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: IDs as a shift list, pointer as an integer, one held word
   int m_id [N];
   int m_ptr = 0;
   bit m_v = 0;
   int m_d = 0;
   int m_s = 0;

   always @(negedge clk) begin
      int win;
      bit found;
      bit load;
      int exp_mr;
      if (!rst) begin
         foreach (m_id[i]) m_id[i] = 0;
         m_ptr = 0; m_v = 0; m_d = 0; m_s = 0;
      end
      found = 0;
      win = 0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (!found && rst && master_valid[j] && m_id[j] == int'(tag) && !set_id) begin
            found = 1; win = j;
         end
      end
      load = !m_v || slave_ready;
      exp_mr = (found && load) ? (1 << win) : 0;
      check("model master_ready", int'(master_ready), exp_mr);
      check("model slave_valid", int'(slave_valid), int'(m_v));
      check("model slave_data", int'(slave_data), m_d);
      check("model slave_src", int'(slave_src), m_s);
      check("model ID_scan_out", int'(ID_scan_out), m_id[N-1]);
      if (rst) begin
         if (set_id) begin
            for (int i = N - 1; i > 0; i--) m_id[i] = m_id[i-1];
            m_id[0] = int'(ID_scan_in);
         end
         if (found && load) begin
            m_v = 1; m_d = int'(master_data[win*DW +: DW]); m_s = win; m_ptr = (win + 1) % N;
         end else if (slave_ready) begin
            m_v = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scan_all(input int v);
      set_id = 1'b1;
      for (int i = 0; i < N; i++) begin
         ID_scan_in = IW'(v);
         tick();
      end
      set_id = 1'b0;
   endtask

   initial begin
      int exp_rr [9];
      int held;
      for (int i = 0; i < N; i++) master_data[i*DW +: DW] = DW'(8'h10 + i);
      tick(); tick();
      check("reset slave_valid", int'(slave_valid), 0);
      check("reset ID_scan_out", int'(ID_scan_out), 0);
      check("reset master_ready", int'(master_ready), 0);
      rst = 1'b1;
      tick();
      // scan 8,7,...,1 so port i holds i+1
      set_id = 1'b1;
      for (int v = 8; v >= 1; v--) begin
         ID_scan_in = IW'(v);
         tick();
      end
      set_id = 1'b0;
      check("scan ID_scan_out", int'(ID_scan_out), 8);
      // single match on tag 3 -> port 2
      tag = 4'd3; master_valid = 8'hFF; slave_ready = 1'b1;
      #1 check("single master_ready", int'(master_ready), 8'h04);
      for (int c = 0; c < 4; c++) begin
         tick();
         check("single slave_data", int'(slave_data), 8'h12);
         check("single slave_src", int'(slave_src), 2);
      end
      // round robin with all IDs equal, starting from a fresh pointer
      master_valid = '0; rst = 1'b0; tick(); rst = 1'b1;
      scan_all(5);
      tag = 4'd5; master_valid = 8'hFF;
      exp_rr = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
      for (int c = 0; c < 9; c++) begin
         tick();
         check("rr slave_valid", int'(slave_valid), 1);
         check("rr slave_src", int'(slave_src), exp_rr[c]);
      end
      master_valid = 8'hF7;
      tick(); check("skip src a", int'(slave_src), 1);
      tick(); check("skip src b", int'(slave_src), 2);
      tick(); check("skip src c", int'(slave_src), 4);
      // backpressure holds port 4's word
      slave_ready = 1'b0;
      held = int'(slave_data);
      #1 check("bp master_ready", int'(master_ready), 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("bp slave_data", int'(slave_data), held);
         check("bp master_ready hold", int'(master_ready), 0);
      end
      slave_ready = 1'b1;
      tick();
      check("release src", int'(slave_src), 5);
      check("release data", int'(slave_data), 8'h15);
      // scan during traffic: held word drains, no new transfers, pointer kept
      set_id = 1'b1; ID_scan_in = 4'd5;
      #1 check("scan master_ready", int'(master_ready), 0);
      tick(); check("scan drain", int'(slave_valid), 0);
      tick(); check("scan idle", int'(slave_valid), 0);
      set_id = 1'b0;
      tick();
      check("after scan src", int'(slave_src), 6);
      // asynchronous reset while a word is held
      check("pre-reset valid", int'(slave_valid), 1);
      rst = 1'b0;
      #1;
      check("async slave_valid", int'(slave_valid), 0);
      check("async slave_data", int'(slave_data), 0);
      check("async ID_scan_out", int'(ID_scan_out), 0);
      tick(); tick();
      tag = 4'd0; master_valid = 8'hF6;
      rst = 1'b1;
      tick();
      check("post-reset src", int'(slave_src), 1);
      check("post-reset data", int'(slave_data), 8'h11);
      tick();
      check("post-reset next src", int'(slave_src), 2);
      master_valid = '0;
      tick(); tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
